lsnn_neuron_scheduler: RTL and testbench
========================================

LSNN_NEURON_SCHEDULER -- requirements
Module: lsnn_neuron_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 4: number of time-multiplexed neurons; SHALL be a power of two, 2..16.
REQ-002 Parameter DATA_W, default 8: width of current, state, adaptation and threshold.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-high (asserted when 1).
REQ-005 tick  in  1  timestep request; accepted only in IDLE.
REQ-006 busy  out  1  high in SWEEP and DONE.
REQ-007 cur_we  in  1  current write strobe.
REQ-008 cur_idx  in  log2(NUM_NEURONS)  target neuron for the current write.
REQ-009 cur_data  in  DATA_W  input current value.
REQ-010 spike_vec  out  NUM_NEURONS  spike flags from the last sweep, bit i = neuron i.
REQ-011 done  out  1  one-cycle pulse at end of sweep.
REQ-012 thr_sel  in  log2(NUM_NEURONS)  neuron selected for threshold readout.
REQ-013 thr_out  out  DATA_W  combinational threshold of neuron thr_sel.
REQ-014 overrun  out  1  sticky: tick seen while busy.

Function
REQ-015 FSM states IDLE, SWEEP, DONE; IDLE & tick -> SWEEP (idx=0); SWEEP & idx==NUM_NEURONS-1 -> DONE; DONE -> IDLE unconditionally.
REQ-016 One shared update datapath SHALL process neuron idx per SWEEP cycle, idx incrementing by 1 per cycle.
REQ-017 Tick accepted at edge k: neuron i updated at edge k+1+i; done high during the cycle after edge k+NUM_NEURONS; IDLE again after edge k+NUM_NEURONS+1.
REQ-018 Per update, all from pre-edge values: spike = (state >= threshold); state' = cur + (state >> 1); adaptation' = spike ? a + (a >> 2) : (a >> 1) + (a >> 2); threshold' = B0J + adaptation'.
REQ-019 spike_vec[i] SHALL be written with the spike of neuron i on its update edge and hold until the next update of that neuron.
REQ-020 Current registers hold values until rewritten; a sweep does not clear them.
REQ-021 cur_we in same cycle as that neuron's update: update uses the old current, the register stores the new one.
REQ-022 tick while busy SHALL be ignored, SHALL not restart the sweep, and SHALL set overrun.
REQ-023 Arithmetic DATA_W wide; without the saturation feature, overflow wraps modulo 2^DATA_W.

Reset
REQ-024 On rst_n=1, asynchronously: FSM IDLE, idx 0, all state 0, all adaptation ALPHA (8), all threshold B0J (8), all current 0, spike_vec 0, done 0, busy 0, overrun 0.
REQ-025 Reset mid-sweep SHALL abort with no done pulse; the first tick after release starts at neuron 0.

Configuration
REQ-026 Macro LSNN_SAT_EN defined: the state and adaptation additions in REQ-018 SHALL saturate at 2^DATA_W-1; undefined: they wrap per REQ-023.

Structure
REQ-027 Package lsnn_pkg SHALL hold DATA_W default, ALPHA, B0J, and the FSM state enum typedef.
REQ-028 Sub-module lsnn_neuron_core SHALL implement REQ-018 combinationally (with LSNN_SAT_EN handling); the scheduler instantiates it once.

Verification
REQ-029 Reset, then cur[0]=10, three ticks -> neuron 0 after sweeps: (state,adapt,thr,spike) = (10,6,14,0), (15,4,12,0), (17,5,13,1); spike_vec[0]=1 after sweep 3.
REQ-030 Tick at edge k -> busy high edges k..k+NUM_NEURONS+1, done exactly one cycle, 6 cycles tick-to-IDLE with NUM_NEURONS=4.
REQ-031 tick re-asserted mid-sweep -> sweep completes unchanged, overrun=1 until reset.
REQ-032 cur[2]=200, two ticks -> state 200 then 44 (wrap) without LSNN_SAT_EN; 200 then 255 with it.
REQ-033 cur_we idx 1 data 50 in neuron-1 update cycle, old cur 5 -> that sweep state1 uses 5; next sweep uses 50.
REQ-034 rst_n pulsed during neuron 2 update -> no done, all registers at reset values, next tick sweeps from neuron 0.

Source files
------------

// File: rtl/lsnn_pkg.sv
// Shared constants and FSM encoding for the LSNN neuron scheduler.
// Saturating arithmetic is selected with the LSNN_SAT_EN macro in lsnn_neuron_core.
package lsnn_pkg;

    localparam int unsigned LSNN_DATA_W = 8;
    localparam int unsigned ALPHA       = 8;
    localparam int unsigned B0J         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } lsnn_state_e;

endpackage

// File: rtl/lsnn_neuron_core.sv
// Combinational single-neuron update: spike test, leaky state, adaptation and threshold.
// Define LSNN_SAT_EN to saturate the state and adaptation additions instead of wrapping.
module lsnn_neuron_core
    import lsnn_pkg::*;
#(
    parameter int unsigned DATA_W = LSNN_DATA_W
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] st,
    input  logic [DATA_W-1:0] adapt,
    input  logic [DATA_W-1:0] thr,
    output logic              spike_c,
    output logic [DATA_W-1:0] st_c,
    output logic [DATA_W-1:0] adapt_c,
    output logic [DATA_W-1:0] thr_c
);

    logic [DATA_W-1:0] a_base;

`ifdef LSNN_SAT_EN
    logic [DATA_W:0] st_sum;
    logic [DATA_W:0] a_sum;
`endif

    // Both adaptation branches share "+ (a >> 2)"; only the first term depends on the spike.
    always_comb begin
        spike_c = (st >= thr);
        a_base  = spike_c ? adapt : (adapt >> 1);
`ifdef LSNN_SAT_EN
        st_sum  = {1'b0, cur} + {1'b0, (st >> 1)};
        a_sum   = {1'b0, a_base} + {1'b0, (adapt >> 2)};
        st_c    = st_sum[DATA_W] ? {DATA_W{1'b1}} : st_sum[DATA_W-1:0];
        adapt_c = a_sum[DATA_W]  ? {DATA_W{1'b1}} : a_sum[DATA_W-1:0];
`else
        st_c    = cur + (st >> 1);
        adapt_c = a_base + (adapt >> 2);
`endif
        thr_c   = DATA_W'(B0J) + adapt_c;
    end

endmodule

// File: rtl/lsnn_neuron_scheduler.sv
// Time-multiplexed LSNN layer: one shared neuron core swept over all neurons per tick.
// Optional LSNN_SAT_EN macro makes the core saturate instead of wrap.
module lsnn_neuron_scheduler
    import lsnn_pkg::*;
#(
    parameter  int unsigned NUM_NEURONS = 4,
    parameter  int unsigned DATA_W      = LSNN_DATA_W,
    localparam int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    output logic                   busy,
    input  logic                   cur_we,
    input  logic [IDX_W-1:0]       cur_idx,
    input  logic [DATA_W-1:0]      cur_data,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   done,
    input  logic [IDX_W-1:0]       thr_sel,
    output logic [DATA_W-1:0]      thr_out,
    output logic                   overrun
);

    lsnn_state_e      fsm_q;
    lsnn_state_e      fsm_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             upd_en;

    logic [DATA_W-1:0] cur_q   [NUM_NEURONS];
    logic [DATA_W-1:0] st_q    [NUM_NEURONS];
    logic [DATA_W-1:0] adapt_q [NUM_NEURONS];
    logic [DATA_W-1:0] thr_q   [NUM_NEURONS];

    logic              spike_c;
    logic [DATA_W-1:0] st_c;
    logic [DATA_W-1:0] adapt_c;
    logic [DATA_W-1:0] thr_c;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fsm_q <= ST_IDLE;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        idx_d  = idx_q;
        upd_en = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (tick) begin
                    fsm_d = ST_SWEEP;
                    idx_d = '0;
                end
            end
            ST_SWEEP: begin
                upd_en = 1'b1;
                if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                    fsm_d = ST_DONE;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Status flags registered from the next state so they line up with the FSM register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy    <= (fsm_d != ST_IDLE);
            done    <= (fsm_d == ST_DONE);
            overrun <= overrun | (tick & (fsm_q != ST_IDLE));
        end
    end

    // Current registers persist across sweeps; the core sees the pre-edge value on a collision.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                cur_q[i] <= '0;
            end
        end else if (cur_we) begin
            cur_q[cur_idx] <= cur_data;
        end
    end

    lsnn_neuron_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .cur     (cur_q[idx_q]),
        .st      (st_q[idx_q]),
        .adapt   (adapt_q[idx_q]),
        .thr     (thr_q[idx_q]),
        .spike_c (spike_c),
        .st_c    (st_c),
        .adapt_c (adapt_c),
        .thr_c   (thr_c)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                st_q[i]    <= '0;
                adapt_q[i] <= DATA_W'(ALPHA);
                thr_q[i]   <= DATA_W'(B0J);
            end
            spike_vec <= '0;
        end else if (upd_en) begin
            st_q[idx_q]      <= st_c;
            adapt_q[idx_q]   <= adapt_c;
            thr_q[idx_q]     <= thr_c;
            spike_vec[idx_q] <= spike_c;
        end
    end

    assign thr_out = thr_q[thr_sel];

endmodule

// File: tb/tb_lsnn_neuron_scheduler.sv
// Directed bench for lsnn_neuron_scheduler with hand-computed expectations.
module tb_lsnn_neuron_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic          busy;
    logic          cur_we;
    logic [IW-1:0] cur_idx;
    logic [DW-1:0] cur_data;
    logic [N-1:0]  spike_vec;
    logic          done;
    logic [IW-1:0] thr_sel;
    logic [DW-1:0] thr_out;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    lsnn_neuron_scheduler #(
        .NUM_NEURONS (N),
        .DATA_W      (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .busy      (busy),
        .cur_we    (cur_we),
        .cur_idx   (cur_idx),
        .cur_data  (cur_data),
        .spike_vec (spike_vec),
        .done      (done),
        .thr_sel   (thr_sel),
        .thr_out   (thr_out),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_thr(input string tag, input logic [IW-1:0] idx, input logic [DW-1:0] exp);
        thr_sel = idx;
        #1;
        chk(tag, 32'(thr_out), 32'(exp));
    endtask

    task automatic set_cur(input logic [IW-1:0] idx, input logic [DW-1:0] data);
        cur_we   = 1'b1;
        cur_idx  = idx;
        cur_data = data;
        step();
        cur_we   = 1'b0;
    endtask

    // One tick-driven sweep with cycle-exact busy/done checks; optional mid-sweep tick and write.
    task automatic do_sweep(input string tag, input int tick_again_at, input int we_at,
                            input logic [IW-1:0] we_idx, input logic [DW-1:0] we_data);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            chk({tag, "_busy"}, 32'(busy), 32'(c <= 4));
            chk({tag, "_done"}, 32'(done), 32'(c == 4));
            if (c < 5) begin
                if (c == tick_again_at) tick = 1'b1;
                if (c == we_at) begin
                    cur_we   = 1'b1;
                    cur_idx  = we_idx;
                    cur_data = we_data;
                end
                step();
                tick   = 1'b0;
                cur_we = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        tick     = 1'b0;
        cur_we   = 1'b0;
        cur_idx  = '0;
        cur_data = '0;
        thr_sel  = '0;
        #12;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_spike_vec", 32'(spike_vec), 32'd0);
        for (int i = 0; i < 4; i++) chk_thr("rst_thr", IW'(i), 8'd8);
        @(posedge clk);
        #1 rst_n = 1'b0;
        step();

        // Neuron 0 trajectory with cur=10 over three sweeps
        set_cur(2'd0, 8'd10);
        do_sweep("sw1", -1, -1, 2'd0, 8'd0);
        chk("sw1_state0", 32'(dut.st_q[0]), 32'd10);
        chk("sw1_adapt0", 32'(dut.adapt_q[0]), 32'd6);
        chk_thr("sw1_thr0", 2'd0, 8'd14);
        chk("sw1_spike_vec", 32'(spike_vec), 32'h0);

        do_sweep("sw2", -1, -1, 2'd0, 8'd0);
        chk("sw2_state0", 32'(dut.st_q[0]), 32'd15);
        chk("sw2_adapt0", 32'(dut.adapt_q[0]), 32'd4);
        chk_thr("sw2_thr0", 2'd0, 8'd12);
        chk("sw2_spike_vec", 32'(spike_vec), 32'h0);

        do_sweep("sw3", -1, -1, 2'd0, 8'd0);
        chk("sw3_state0", 32'(dut.st_q[0]), 32'd17);
        chk("sw3_adapt0", 32'(dut.adapt_q[0]), 32'd5);
        chk_thr("sw3_thr0", 2'd0, 8'd13);
        chk("sw3_spike_vec", 32'(spike_vec), 32'h1);
        chk_thr("sw3_thr1", 2'd1, 8'd11);

        // Current write colliding with neuron 1's update uses the old current
        set_cur(2'd1, 8'd5);
        do_sweep("sw4", -1, 1, 2'd1, 8'd50);
        chk("sw4_state1_old_cur", 32'(dut.st_q[1]), 32'd5);
        chk("sw4_cur1_stored", 32'(dut.cur_q[1]), 32'd50);
        do_sweep("sw5", -1, -1, 2'd0, 8'd0);
        chk("sw5_state1_new_cur", 32'(dut.st_q[1]), 32'd52);
        chk("sw5_cur0_kept", 32'(dut.cur_q[0]), 32'd10);

        // Overflow on neuron 2, with a tick re-asserted mid-sweep
        set_cur(2'd2, 8'd200);
        do_sweep("sw6", -1, -1, 2'd0, 8'd0);
        chk("sw6_state2", 32'(dut.st_q[2]), 32'd200);
        chk("sw6_overrun", 32'(overrun), 32'd0);
        do_sweep("sw7", 2, -1, 2'd0, 8'd0);
`ifdef LSNN_SAT_EN
        chk("sw7_state2_sat", 32'(dut.st_q[2]), 32'd255);
`else
        chk("sw7_state2_wrap", 32'(dut.st_q[2]), 32'd44);
`endif
        chk("sw7_overrun", 32'(overrun), 32'd1);
        step();
        step();
        step();
        chk("sw7_overrun_sticky", 32'(overrun), 32'd1);
        chk("sw7_idle", 32'(busy), 32'd0);

        // Asynchronous reset during neuron 2's update cycle
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        #2 rst_n = 1'b1;
        #1;
        chk("ar_busy_async", 32'(busy), 32'd0);
        chk("ar_overrun_async", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("ar_no_done", 32'(done), 32'd0);
            chk("ar_no_busy", 32'(busy), 32'd0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("ar_state", 32'(dut.st_q[i]), 32'd0);
            chk("ar_adapt", 32'(dut.adapt_q[i]), 32'd8);
            chk("ar_cur", 32'(dut.cur_q[i]), 32'd0);
            chk_thr("ar_thr", IW'(i), 8'd8);
        end
        chk("ar_spike_vec", 32'(spike_vec), 32'h0);
        chk("ar_overrun", 32'(overrun), 32'd0);

        set_cur(2'd0, 8'd7);
        do_sweep("sw8", -1, -1, 2'd0, 8'd0);
        chk("sw8_state0", 32'(dut.st_q[0]), 32'd7);
        chk("sw8_state1", 32'(dut.st_q[1]), 32'd0);
        chk_thr("sw8_thr0", 2'd0, 8'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
